spi_master: RTL

SPI initiator that drives `sck`, `mosi` and `cs` and samples `miso`, in mode 0 (CPOL=0, CPHA=0), MSB first, one `DATA_WIDTH`-bit frame per transaction. It is the host-side counterpart of the SPI peripheral used by the `fast_serial_sort` wrapper. It lets an on-chip test harness or a second FPGA exercise the sorter over the same four-wire link a microcontroller would use.

---
 rtl/spi_master.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI mode-0 initiator: shifts one DATA_WIDTH-bit frame out on mosi (MSB first) while sampling miso.
// Latency: done pulses (2*DATA_WIDTH+1)*CLK_DIV+1 cycles after the accepting start; all outputs registered.
// Backpressure: start is taken only in IDLE; requests while busy are dropped, never queued.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_to_send,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_received,
  output logic                  sck,
  output logic                  mosi,
  output logic                  cs,
  input  logic                  miso
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, FINISH} state_t;

  state_t                state, state_nxt;
  logic [DW-1:0]         div_cnt, div_nxt;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] tx_sr, tx_nxt;
  logic [DATA_WIDTH-1:0] rx_sr, rx_nxt;
  logic [DATA_WIDTH-1:0] dr_nxt;
  logic                  sck_nxt, mosi_nxt, cs_nxt, busy_nxt, done_nxt;
  logic                  div_last;

  assign div_last = (div_cnt == DIV_LAST);

  // State and every output register; the comb block below precomputes next values so outputs stay glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      data_received <= '0;
      sck           <= 1'b0;
      mosi          <= 1'b0;
      cs            <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      div_cnt       <= div_nxt;
      bit_cnt       <= bit_nxt;
      tx_sr         <= tx_nxt;
      rx_sr         <= rx_nxt;
      data_received <= dr_nxt;
      sck           <= sck_nxt;
      mosi          <= mosi_nxt;
      cs            <= cs_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

  // Next-state and next-output logic; each phase lasts CLK_DIV cycles, actions fire on phase entry.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_last ? '0 : div_cnt + 1'b1;
    bit_nxt   = bit_cnt;
    tx_nxt    = tx_sr;
    rx_nxt    = rx_sr;
    dr_nxt    = data_received;
    sck_nxt   = sck;
    mosi_nxt  = mosi;
    cs_nxt    = cs;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        div_nxt = '0;
        if (start) begin
          state_nxt = SETUP;
          tx_nxt    = data_to_send;
          rx_nxt    = '0;
          bit_nxt   = '0;
          cs_nxt    = 1'b0;
          sck_nxt   = 1'b0;
          mosi_nxt  = data_to_send[DATA_WIDTH-1];
          busy_nxt  = 1'b1;
        end
      end
      SETUP, LOW: begin
        // Rising sck edge: the far end has had a full half-period to settle miso.
        if (div_last) begin
          state_nxt = HIGH;
          sck_nxt   = 1'b1;
          rx_nxt    = {rx_sr[DATA_WIDTH-2:0], miso};
          bit_nxt   = bit_cnt + 1'b1;
        end
      end
      HIGH: begin
        if (div_last) begin
          sck_nxt = 1'b0;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = HOLD;
          end else begin
            state_nxt = LOW;
            tx_nxt    = tx_sr << 1;
            mosi_nxt  = tx_sr[DATA_WIDTH-2];
          end
        end
      end
      HOLD: begin
        // cs stays low one more half-period after the last falling edge.
        if (div_last) begin
          state_nxt = FINISH;
          cs_nxt    = 1'b1;
          done_nxt  = 1'b1;
          dr_nxt    = rx_sr;
          mosi_nxt  = 1'b0;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
        div_nxt   = '0;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
